// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes,
// default latencies and FSM state encoding.
package md_unit_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // True for the four ops that occupy the unit for several cycles.
   function automatic logic is_muldiv(input logic [2:0] op);
      return (op >= 3'd1) && (op <= 3'd4);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// start/md_op/A/B are sampled on the rising edge; results are plain levels.
interface md_unit_if;

   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        md_stall_src;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output start, md_op, A, B,
      input  busy, md_stall_src, HI, LO
   );

   modport slave (
      input  start, md_op, A, B,
      output busy, md_stall_src, HI, LO
   );

endinterface

// File: rtl/md_unit_calc.sv
// Combinational MIPS mult/div datapath: {HI,LO} result and a divide-by-zero flag.
module md_unit_calc
   import md_unit_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_result,
   output logic        o_div0
);

   logic [31:0]        w_b_safe;
   logic signed [32:0] w_sa;
   logic signed [32:0] w_sb;
   logic signed [32:0] w_sq;
   logic signed [32:0] w_sr;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;
   logic signed [63:0] w_smul;
   logic [63:0]        w_umul;

   assign o_div0   = (i_b == 32'd0) && ((i_op == MD_DIV) || (i_op == MD_DIVU));
   assign w_b_safe = (i_b == 32'd0) ? 32'd1 : i_b;

   // 33-bit signed divide so that 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
   assign w_sa = {i_a[31], i_a};
   assign w_sb = {w_b_safe[31], w_b_safe};
   assign w_sq = w_sa / w_sb;
   assign w_sr = w_sa % w_sb;
   assign w_uq = i_a / w_b_safe;
   assign w_ur = i_a % w_b_safe;

   assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_umul = {32'd0, i_a} * {32'd0, i_b};

   always_comb begin
      o_result = 64'd0;
      case (i_op)
         MD_MULT:  o_result = w_smul;
         MD_MULTU: o_result = w_umul;
         MD_DIV:   o_result = {w_sr[31:0], w_sq[31:0]};
         MD_DIVU:  o_result = {w_ur, w_uq};
         default:  o_result = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers plus a fixed-latency busy window
// that the hazard unit uses to stall MD instructions issued behind it.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   md_unit_if.slave   md,
   output md_state_e  o_dbg_state
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [63:0]      r_res, w_res_nxt;
   logic             r_div0, w_div0_nxt;
   logic [31:0]      r_hi, w_hi_nxt;
   logic [31:0]      r_lo, w_lo_nxt;
   logic [63:0]      w_calc_res;
   logic             w_calc_div0;
   logic             w_is_mult;

   md_unit_calc u_calc (
      .i_op     (md.md_op),
      .i_a      (md.A),
      .i_b      (md.B),
      .o_result (w_calc_res),
      .o_div0   (w_calc_div0)
   );

   assign w_is_mult = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_res_nxt   = r_res;
      w_div0_nxt  = r_div0;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      case (r_state)
         ST_IDLE: begin
            if (md.start) begin
               if (is_muldiv(md.md_op)) begin
                  w_state_nxt = ST_RUN;
                  w_res_nxt   = w_calc_res;
                  w_div0_nxt  = w_calc_div0;
                  w_cnt_nxt   = w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               end else if (md.md_op == MD_MTHI) begin
                  w_hi_nxt = md.A;
               end else if (md.md_op == MD_MTLO) begin
                  w_lo_nxt = md.A;
               end
            end
         end
         ST_RUN: begin
            // Any start seen here is dropped; the hazard unit should never issue one.
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               if (!r_div0) begin
                  w_hi_nxt = r_res[63:32];
                  w_lo_nxt = r_res[31:0];
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_res   <= 64'd0;
         r_div0  <= 1'b0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_res   <= w_res_nxt;
         r_div0  <= w_div0_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   assign md.busy         = (r_state == ST_RUN);
   assign md.md_stall_src = md.busy | (md.start & is_muldiv(md.md_op));
   assign md.HI           = r_hi;
   assign md.LO           = r_lo;
   assign o_dbg_state     = r_state;

endmodule
